// File: rtl/aes_mixcol_serial.sv
// Byte-serial AES MixColumns with ping-pong collector/output buffer.
// Define AES_MIXCOL_INV_EN to add the inv port (InvMixColumns per column).
module aes_mixcol_serial #(
  parameter int COLS_PER_BLOCK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_byte,
  input  logic       out_ready,
  output logic       block_last
`ifdef AES_MIXCOL_INV_EN
  ,
  input  logic       inv
`endif
);

  localparam int CW =
    (COLS_PER_BLOCK > 1) ? $clog2(COLS_PER_BLOCK) : 1;
  localparam logic [CW-1:0] COL_MAX =
    CW'(COLS_PER_BLOCK - 1);

  function automatic logic [7:0] xt(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m3(
    input logic [7:0] x
  );
    return xt(x) ^ x;
  endfunction

  function automatic logic [7:0] m9(
    input logic [7:0] x
  );
    return xt(xt(xt(x))) ^ x;
  endfunction

  function automatic logic [7:0] mb(
    input logic [7:0] x
  );
    return xt(xt(xt(x))) ^ xt(x) ^ x;
  endfunction

  function automatic logic [7:0] md(
    input logic [7:0] x
  );
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
  endfunction

  function automatic logic [7:0] me(
    input logic [7:0] x
  );
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
  endfunction

  // Row i uses a[i], a[i+1], a[i+2], a[i+3] with
  // rotating coefficients {2,3,1,1} or {e,b,d,9}.
  function automatic logic [3:0][7:0] mix(
    input logic [3:0][7:0] a,
    input logic            iv
  );
    logic [3:0][7:0] r;
    logic [1:0]      k0, k1, k2, k3;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      k0 = 2'(i);
      k1 = 2'(i + 1);
      k2 = 2'(i + 2);
      k3 = 2'(i + 3);
      if (iv)
        r[i] = me(a[k0]) ^ mb(a[k1])
             ^ md(a[k2]) ^ m9(a[k3]);
      else
        r[i] = xt(a[k0]) ^ m3(a[k1])
             ^ a[k2] ^ a[k3];
    end
    return r;
  endfunction

  logic [3:0][7:0] a_q;
  logic [3:0][7:0] o_q;
  logic [2:0]      in_cnt;
  logic [1:0]      out_idx;
  logic            ov_q;
  logic [CW-1:0]   col_cnt;

  logic            inv_sel;
  logic            take;
  logic            last_take;
  logic            buf_free;
  logic            xfer;
  logic            accept;
  logic [3:0][7:0] mixed;

`ifdef AES_MIXCOL_INV_EN
  assign inv_sel = inv;
`else
  assign inv_sel = 1'b0;
`endif

  always_comb begin
    take      = ov_q && out_ready;
    last_take = take && (out_idx == 2'd3);
    buf_free  = !ov_q || last_take;
    xfer      = (in_cnt == 3'd4) && buf_free;
    in_ready  = (in_cnt < 3'd4) || xfer;
    accept    = in_valid && in_ready;
    mixed     = mix(a_q, inv_sel);
  end

  assign out_valid  = ov_q;
  assign out_byte   = o_q[out_idx];
  assign block_last = ov_q && (out_idx == 2'd3)
                   && (col_cnt == COL_MAX);

  // Collector side
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      in_cnt <= 3'd0;
    end else if (xfer) begin
      // Freed collector can take a new a0 at once
      if (accept) begin
        a_q[0] <= in_byte;
        in_cnt <= 3'd1;
      end else begin
        in_cnt <= 3'd0;
      end
    end else if (accept) begin
      a_q[in_cnt[1:0]] <= in_byte;
      in_cnt           <= in_cnt + 3'd1;
    end
  end

  // Output side
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q     <= '0;
      out_idx <= 2'd0;
      ov_q    <= 1'b0;
    end else if (xfer) begin
      o_q     <= mixed;
      out_idx <= 2'd0;
      ov_q    <= 1'b1;
    end else if (take) begin
      out_idx <= out_idx + 2'd1;
      if (out_idx == 2'd3)
        ov_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      col_cnt <= '0;
    else if (last_take)
      col_cnt <= (col_cnt == COL_MAX)
               ? '0 : col_cnt + CW'(1);
  end

endmodule

// File: tb/tb_aes_mixcol_serial.sv
// Directed bench for aes_mixcol_serial.
// Define AES_MIXCOL_INV_EN to also exercise the inverse transform.
module tb_aes_mixcol_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready = 1'b0;
  logic       block_last;
`ifdef AES_MIXCOL_INV_EN
  logic       inv = 1'b0;
`endif

  aes_mixcol_serial #(.COLS_PER_BLOCK(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_byte   (out_byte),
    .out_ready  (out_ready),
    .block_last (block_last)
`ifdef AES_MIXCOL_INV_EN
    ,
    .inv        (inv)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = -1;
  bit all_rdy;

  logic [7:0] byte_q[$];
  logic       last_q[$];
  int         cyc_q[$];
  logic       s_rdy;
  logic       s_ov;
  logic [7:0] s_ob;

  // One clock: drive at negedge, sample 1ns later, end on posedge.
  task automatic cycle(input logic v,
                       input logic [7:0] b,
                       input logic r);
    @(negedge clk);
    in_valid  = v;
    in_byte   = b;
    out_ready = r;
    #1;
    s_rdy = in_ready;
    s_ov  = out_valid;
    s_ob  = out_byte;
    if (!rst && out_valid && out_ready) begin
      byte_q.push_back(out_byte);
      last_q.push_back(block_last);
      cyc_q.push_back(cyc);
    end
    if (!rst && in_valid && in_ready)
      acc_cyc = cyc;
    if (v && !in_ready)
      all_rdy = 1'b0;
    cyc++;
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic clear_log();
    byte_q.delete();
    last_q.delete();
    cyc_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    cycle(1'b0, 8'h00, 1'b1);
    n_chk++;
    if (s_ov !== 1'b0) begin
      n_fail++;
      $display("FAIL reset out_valid got %b want 0", s_ov);
    end
    n_chk++;
    if (s_ob !== 8'h00) begin
      n_fail++;
      $display("FAIL reset out_byte got %h want 00", s_ob);
    end
    n_chk++;
    if (s_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset in_ready got %b want 1", s_rdy);
    end
    n_chk++;
    if (block_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset block_last got %b want 0",
               block_last);
    end
  endtask

  task automatic test_single();
    logic [7:0] din[4] = '{8'hdb, 8'h13, 8'h53, 8'h45};
    logic [7:0] exp[4] = '{8'h8e, 8'h4d, 8'ha1, 8'hbc};
    clear_log();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, din[i], 1'b1);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 8'h00, 1'b1);
    n_chk++;
    if (byte_q.size() != 4) begin
      n_fail++;
      $display("FAIL single count got %0d want 4",
               byte_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (byte_q[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL single b%0d got %h want %h",
                   i, byte_q[i], exp[i]);
        end
      end
      n_chk++;
      if (cyc_q[0] != acc_cyc + 2) begin
        n_fail++;
        $display("FAIL latency b0 cycle got %0d want %0d",
                 cyc_q[0], acc_cyc + 2);
      end
      n_chk++;
      if (cyc_q[3] != acc_cyc + 5) begin
        n_fail++;
        $display("FAIL latency b3 cycle got %0d want %0d",
                 cyc_q[3], acc_cyc + 5);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] din[8] = '{8'hf2, 8'h0a, 8'h22, 8'h5c,
                           8'h01, 8'h01, 8'h01, 8'h01};
    logic [7:0] exp[8] = '{8'h9f, 8'hdc, 8'h58, 8'h9d,
                           8'h01, 8'h01, 8'h01, 8'h01};
    clear_log();
    all_rdy = 1'b1;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, din[i], 1'b1);
    n_chk++;
    if (all_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b in_ready dropped got 0 want 1");
    end
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 8'h00, 1'b1);
    n_chk++;
    if (byte_q.size() != 8) begin
      n_fail++;
      $display("FAIL b2b count got %0d want 8",
               byte_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (byte_q[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL b2b byte%0d got %h want %h",
                   i, byte_q[i], exp[i]);
        end
      end
      n_chk++;
      if (cyc_q[7] - cyc_q[0] != 7) begin
        n_fail++;
        $display("FAIL b2b span got %0d want 7",
                 cyc_q[7] - cyc_q[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] din[4] = '{8'hdb, 8'h13, 8'h53, 8'h45};
    logic [7:0] exp[8] = '{8'h8e, 8'h4d, 8'ha1, 8'hbc,
                           8'hc6, 8'hc6, 8'hc6, 8'hc6};
    do_reset();
    clear_log();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, din[i], 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 8'hc6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      n_chk++;
      if (s_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp in_ready got %b want 0", s_rdy);
      end
      n_chk++;
      if (s_ov !== 1'b1 || s_ob !== 8'h8e) begin
        n_fail++;
        $display("FAIL bp hold got %b/%h want 1/8e",
                 s_ov, s_ob);
      end
    end
    for (int i = 0; i < 12; i++)
      cycle(1'b0, 8'h00, 1'b1);
    n_chk++;
    if (byte_q.size() != 8) begin
      n_fail++;
      $display("FAIL bp count got %0d want 8",
               byte_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (byte_q[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL bp byte%0d got %h want %h",
                   i, byte_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_block_last();
    logic [7:0] din[4] = '{8'hd4, 8'hbf, 8'h5d, 8'h30};
    logic       exp;
    do_reset();
    clear_log();
    for (int i = 0; i < 32; i++)
      cycle(1'b1, din[i % 4], 1'b1);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 8'h00, 1'b1);
    n_chk++;
    if (byte_q.size() != 32) begin
      n_fail++;
      $display("FAIL blk count got %0d want 32",
               byte_q.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        exp = (i == 15) || (i == 31);
        n_chk++;
        if (last_q[i] !== exp) begin
          n_fail++;
          $display("FAIL blk last%0d got %b want %b",
                   i, last_q[i], exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] din[4] = '{8'hd4, 8'hbf, 8'h5d, 8'h30};
    logic [7:0] exp[4] = '{8'h04, 8'h66, 8'h81, 8'he5};
    int guard;
    do_reset();
    clear_log();
    cycle(1'b1, 8'h11, 1'b1);
    cycle(1'b1, 8'h22, 1'b1);
    do_reset();
    cycle(1'b0, 8'h00, 1'b1);
    n_chk++;
    if (s_ov !== 1'b0 || s_ob !== 8'h00 || s_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst1 got %b/%h/%b want 0/00/1",
               s_ov, s_ob, s_rdy);
    end
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 8'h5a, 1'b1);
    guard = 0;
    while (byte_q.size() < 1 && guard < 20) begin
      cycle(1'b0, 8'h00, 1'b1);
      guard++;
    end
    n_chk++;
    if (byte_q.size() < 1) begin
      n_fail++;
      $display("FAIL rst2 timeout got no b0 want b0");
    end
    do_reset();
    cycle(1'b0, 8'h00, 1'b1);
    n_chk++;
    if (s_ov !== 1'b0 || s_ob !== 8'h00 || s_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst2 got %b/%h/%b want 0/00/1",
               s_ov, s_ob, s_rdy);
    end
    clear_log();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, din[i], 1'b1);
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 8'h00, 1'b1);
    n_chk++;
    if (byte_q.size() != 4) begin
      n_fail++;
      $display("FAIL rstcol count got %0d want 4",
               byte_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (byte_q[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL rstcol b%0d got %h want %h",
                   i, byte_q[i], exp[i]);
        end
      end
    end
  endtask

`ifdef AES_MIXCOL_INV_EN
  task automatic test_inv();
    logic [7:0] din[12] = '{8'h8e, 8'h4d, 8'ha1, 8'hbc,
                            8'hdb, 8'h13, 8'h53, 8'h45,
                            8'h9f, 8'hdc, 8'h58, 8'h9d};
    logic [7:0] exp[12] = '{8'hdb, 8'h13, 8'h53, 8'h45,
                            8'h8e, 8'h4d, 8'ha1, 8'hbc,
                            8'hf2, 8'h0a, 8'h22, 8'h5c};
    logic       iv[3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    clear_log();
    for (int c = 0; c < 3; c++) begin
      inv = iv[c];
      for (int i = 0; i < 4; i++)
        cycle(1'b1, din[c * 4 + i], 1'b1);
      for (int i = 0; i < 6; i++)
        cycle(1'b0, 8'h00, 1'b1);
    end
    inv = 1'b0;
    n_chk++;
    if (byte_q.size() != 12) begin
      n_fail++;
      $display("FAIL inv count got %0d want 12",
               byte_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_chk++;
        if (byte_q[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL inv byte%0d got %h want %h",
                   i, byte_q[i], exp[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_block_last();
    test_reset_mid();
`ifdef AES_MIXCOL_INV_EN
    test_inv();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
